// File: rtl/vsid_inserter.sv
// Single-stage AXI-Stream tagger: overwrites the encap MAC and the 24-bit VXLAN/NVGRE VSID per packet.
// Optional packet statistics outputs are enabled with `define VSID_INSERT_STATS_EN.
`timescale 1ns/1ps

module vsid_inserter #(
    parameter int unsigned AXIS_BUS_WIDTH    = 64,
    parameter int unsigned AXIS_ID_WIDTH     = 4,
    parameter int unsigned MAX_PACKET_LENGTH = 1522
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [AXIS_BUS_WIDTH-1:0]         axis_in_tdata,
    input  logic [AXIS_ID_WIDTH-1:0]          axis_in_tid,
    input  logic [AXIS_BUS_WIDTH/8-1:0]       axis_in_tkeep,
    input  logic                              axis_in_tlast,
    input  logic                              axis_in_tvalid,
    output logic                              axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]         axis_out_tdata,
    output logic [AXIS_ID_WIDTH-1:0]          axis_out_tid,
    output logic [AXIS_BUS_WIDTH/8-1:0]       axis_out_tkeep,
    output logic                              axis_out_tlast,
    output logic                              axis_out_tvalid,
    input  logic                              axis_out_tready,
    input  logic                              vsid_config_regs,
    input  logic [82*(2**AXIS_ID_WIDTH)-1:0]  vsid_cam_values
`ifdef VSID_INSERT_STATS_EN
    ,
    output logic [31:0]                       stat_tagged_pkts,
    output logic [31:0]                       stat_short_pkts
`endif
);

    localparam int unsigned NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8;
    localparam int unsigned NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH;
    localparam int unsigned CNT_W          = $clog2(MAX_PACKET_LENGTH + 1);
    localparam int unsigned SLICE_W        = 82;
    localparam int unsigned MAC_BYTES      = 6;
    localparam int unsigned VSID_BYTES     = 3;
    localparam int unsigned VXLAN_VSID_OFS = 46;
    localparam int unsigned NVGRE_VSID_OFS = 38;

    typedef enum logic {ST_FIRST, ST_BODY} state_t;

    typedef struct packed {
        logic        mac_en;
        logic [47:0] mac;
        logic        vsid_en;
        logic [23:0] vsid;
    } tag_cfg_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          offset_q;
    tag_cfg_t                  cfg_q;
    logic                      vxlan_q;
    logic [AXIS_BUS_WIDTH-1:0] out_tdata_q;
    logic [AXIS_ID_WIDTH-1:0]  out_tid_q;
    logic [NUM_BUS_BYTES-1:0]  out_tkeep_q;
    logic                      out_tlast_q;
    logic                      out_tvalid_q;

    tag_cfg_t                  cam_cfg [NUM_AXIS_ID];
    logic [8*NUM_AXIS_ID-1:0]  unused_vsid_hi;
    tag_cfg_t                  cur_cfg;
    logic                      cur_vxlan;
    logic [CNT_W-1:0]          cur_ofs;
    logic                      first_beat;
    logic                      load;
    logic                      accept;
    logic [AXIS_BUS_WIDTH-1:0] tdata_d;
    logic [CNT_W-1:0]          offset_d;
    int unsigned               vsid_base;
    logic [7:0]                mac_b  [MAC_BYTES];
    logic [7:0]                vsid_b [VSID_BYTES];

    assign load           = !out_tvalid_q || axis_out_tready;
    assign axis_in_tready = !areset && load;
    assign accept         = axis_in_tvalid && axis_in_tready;

    // Unpack CAM slices; vsid[31:24] carries no meaning
    always_comb begin
        unused_vsid_hi = '0;
        for (int j = 0; j < NUM_AXIS_ID; j++) begin
            cam_cfg[j].mac_en  = vsid_cam_values[SLICE_W*j + 81];
            cam_cfg[j].mac     = vsid_cam_values[SLICE_W*j + 33 +: 48];
            cam_cfg[j].vsid_en = vsid_cam_values[SLICE_W*j + 32];
            cam_cfg[j].vsid    = vsid_cam_values[SLICE_W*j +: 24];
            unused_vsid_hi[8*j +: 8] = vsid_cam_values[SLICE_W*j + 24 +: 8];
        end
    end

    // First beat uses the live configuration, later beats the latched copy
    always_comb begin
        int unsigned pos;
        int unsigned ofs_sum;
        pos        = 0;
        first_beat = (state_q == ST_FIRST);
        cur_cfg    = first_beat ? cam_cfg[axis_in_tid] : cfg_q;
        cur_vxlan  = first_beat ? vsid_config_regs : vxlan_q;
        cur_ofs    = first_beat ? '0 : offset_q;
        vsid_base  = cur_vxlan ? VXLAN_VSID_OFS : NVGRE_VSID_OFS;
        for (int i = 0; i < MAC_BYTES; i++) begin
            mac_b[i] = cur_cfg.mac[8*(MAC_BYTES-1-i) +: 8];
        end
        for (int i = 0; i < VSID_BYTES; i++) begin
            vsid_b[i] = cur_cfg.vsid[8*(VSID_BYTES-1-i) +: 8];
        end
        tdata_d = axis_in_tdata;
        for (int k = 0; k < NUM_BUS_BYTES; k++) begin
            pos = 32'(cur_ofs) + 32'(k);
            if (axis_in_tkeep[k]) begin
                if (cur_cfg.mac_en && pos < MAC_BYTES) begin
                    tdata_d[8*k +: 8] = mac_b[3'(pos)];
                end
                if (cur_cfg.vsid_en && pos >= vsid_base && pos < vsid_base + VSID_BYTES) begin
                    tdata_d[8*k +: 8] = vsid_b[2'(pos - vsid_base)];
                end
            end
        end
        ofs_sum  = 32'(cur_ofs) + NUM_BUS_BYTES;
        offset_d = (ofs_sum >= MAX_PACKET_LENGTH) ? CNT_W'(MAX_PACKET_LENGTH) : CNT_W'(ofs_sum);
    end

`ifdef VSID_INSERT_STATS_EN
    logic [31:0] tagged_q;
    logic [31:0] short_q;
    logic        pkt_tagged;
    logic        pkt_short;

    // Short = packet ends before the last byte of an enabled field
    always_comb begin
        int unsigned kept;
        int unsigned pkt_len;
        kept = 0;
        for (int k = 0; k < NUM_BUS_BYTES; k++) begin
            kept = kept + 32'(axis_in_tkeep[k]);
        end
        pkt_len    = 32'(cur_ofs) + kept;
        pkt_tagged = cur_cfg.mac_en || cur_cfg.vsid_en;
        pkt_short  = (cur_cfg.mac_en && pkt_len < MAC_BYTES) ||
                     (cur_cfg.vsid_en && pkt_len < vsid_base + VSID_BYTES);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            tagged_q <= '0;
            short_q  <= '0;
        end else if (accept && axis_in_tlast && pkt_tagged) begin
            tagged_q <= tagged_q + 32'd1;
            if (pkt_short) begin
                short_q <= short_q + 32'd1;
            end
        end
    end

    assign stat_tagged_pkts = tagged_q;
    assign stat_short_pkts  = short_q;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_FIRST;
            offset_q     <= '0;
            cfg_q        <= '0;
            vxlan_q      <= 1'b0;
            out_tdata_q  <= '0;
            out_tid_q    <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
        end else begin
            if (load) begin
                out_tvalid_q <= axis_in_tvalid;
            end
            if (accept) begin
                out_tdata_q <= tdata_d;
                out_tid_q   <= axis_in_tid;
                out_tkeep_q <= axis_in_tkeep;
                out_tlast_q <= axis_in_tlast;
                if (first_beat) begin
                    cfg_q   <= cur_cfg;
                    vxlan_q <= cur_vxlan;
                end
                if (axis_in_tlast) begin
                    state_q  <= ST_FIRST;
                    offset_q <= '0;
                end else begin
                    state_q  <= ST_BODY;
                    offset_q <= offset_d;
                end
            end
        end
    end

    assign axis_out_tdata  = out_tdata_q;
    assign axis_out_tid    = out_tid_q;
    assign axis_out_tkeep  = out_tkeep_q;
    assign axis_out_tlast  = out_tlast_q;
    assign axis_out_tvalid = out_tvalid_q;

endmodule

// File: tb/tb_vsid_inserter.sv
// Scoreboard bench for vsid_inserter: directed tagging vectors, reset, config toggling and random backpressure.
`timescale 1ns/1ps

module tb_vsid_inserter;

    localparam int unsigned NB  = 8;
    localparam int unsigned NID = 16;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  tid;
    } beat_t;
    typedef logic [7:0] bytes_t [$];
    typedef beat_t beats_t [$];

    logic              aclk = 1'b0;
    logic              areset;
    logic [63:0]       axis_in_tdata;
    logic [3:0]        axis_in_tid;
    logic [7:0]        axis_in_tkeep;
    logic              axis_in_tlast;
    logic              axis_in_tvalid;
    logic              axis_in_tready;
    logic [63:0]       axis_out_tdata;
    logic [3:0]        axis_out_tid;
    logic [7:0]        axis_out_tkeep;
    logic              axis_out_tlast;
    logic              axis_out_tvalid;
    logic              axis_out_tready = 1'b1;
    logic              vsid_config_regs;
    logic [82*NID-1:0] vsid_cam_values;
`ifdef VSID_INSERT_STATS_EN
    logic [31:0]       stat_tagged_pkts;
    logic [31:0]       stat_short_pkts;
`endif

    vsid_inserter dut (
        .aclk             (aclk),
        .areset           (areset),
        .axis_in_tdata    (axis_in_tdata),
        .axis_in_tid      (axis_in_tid),
        .axis_in_tkeep    (axis_in_tkeep),
        .axis_in_tlast    (axis_in_tlast),
        .axis_in_tvalid   (axis_in_tvalid),
        .axis_in_tready   (axis_in_tready),
        .axis_out_tdata   (axis_out_tdata),
        .axis_out_tid     (axis_out_tid),
        .axis_out_tkeep   (axis_out_tkeep),
        .axis_out_tlast   (axis_out_tlast),
        .axis_out_tvalid  (axis_out_tvalid),
        .axis_out_tready  (axis_out_tready),
        .vsid_config_regs (vsid_config_regs),
        .vsid_cam_values  (vsid_cam_values)
`ifdef VSID_INSERT_STATS_EN
        ,
        .stat_tagged_pkts (stat_tagged_pkts),
        .stat_short_pkts  (stat_short_pkts)
`endif
    );

    always #5 aclk = ~aclk;

    beat_t       sb_q [$];
    beats_t      in_q;
    beats_t      exp_q;
    logic [81:0] sl [NID];
    int          checks    = 0;
    int          failures  = 0;
    int          exp_tag   = 0;
    int          exp_short = 0;
    bit          rand_rdy  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic beats_t pack(input bytes_t b, input logic [3:0] tid);
        beats_t q;
        beat_t  bt;
        int     n  = b.size();
        int     nb = (n + NB - 1) / NB;
        for (int i = 0; i < nb; i++) begin
            bt      = '0;
            bt.tid  = tid;
            bt.last = (i == nb - 1);
            for (int k = 0; k < NB; k++) begin
                if (i*NB + k < n) begin
                    bt.data[8*k +: 8] = b[i*NB + k];
                    bt.keep[k]        = 1'b1;
                end
            end
            q.push_back(bt);
        end
        return q;
    endfunction

    function automatic bytes_t zeros(input int n);
        bytes_t b;
        for (int i = 0; i < n; i++) b.push_back(8'h00);
        return b;
    endfunction

    function automatic logic [81:0] mk_slice(input logic men, input logic [47:0] mac,
                                             input logic ven, input logic [31:0] vsid);
        return {men, mac, ven, vsid};
    endfunction

    // Golden model: edit bytes in packet-byte space
    function automatic bytes_t edit(input bytes_t b, input logic vx, input logic [81:0] s);
        bytes_t      r    = b;
        int          base = vx ? 46 : 38;
        logic [47:0] mac  = s[80:33];
        logic [23:0] vs   = s[23:0];
        if (s[81]) for (int i = 0; i < 6; i++) if (i < r.size()) r[i] = mac[47-8*i -: 8];
        if (s[32]) for (int j = 0; j < 3; j++) if (base + j < r.size()) r[base+j] = vs[23-8*j -: 8];
        return r;
    endfunction

    function automatic bit is_short(input int len, input logic vx, input logic [81:0] s);
        int base = vx ? 46 : 38;
        return (s[81] && len < 6) || (s[32] && len < base + 3);
    endfunction

    task automatic set_slice(input int j, input logic [81:0] s);
        sl[j] = s;
        vsid_cam_values[82*j +: 82] = s;
    endtask

    task automatic drive_pkt(input int nbeats, input int chg_at, input logic cfg0);
        bit rdy;
        int budget;
        for (int i = 0; i < nbeats; i++) begin
            axis_in_tdata    = in_q[i].data;
            axis_in_tkeep    = in_q[i].keep;
            axis_in_tlast    = in_q[i].last;
            axis_in_tid      = in_q[i].tid;
            axis_in_tvalid   = 1'b1;
            vsid_config_regs = (i >= chg_at) ? ~cfg0 : cfg0;
            sb_q.push_back(exp_q[i]);
            rdy    = 1'b0;
            budget = 0;
            while (!rdy && budget < 200) begin
                @(negedge aclk);
                rdy = axis_in_tready;
                @(posedge aclk);
                #1;
                budget++;
            end
            if (!rdy) begin
                checks++;
                failures++;
                $display("FAIL in_accept_timeout: beat %0d not accepted in %0d cycles", i, budget);
            end
        end
        axis_in_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (sb_q.size() != 0 && budget < 2000) begin
            @(posedge aclk);
            #1;
            budget++;
        end
        repeat (2) @(posedge aclk);
        #1;
        check("drain_remaining", sb_q.size(), 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef VSID_INSERT_STATS_EN
        check({tag, "_stat_tagged"}, stat_tagged_pkts, exp_tag);
        check({tag, "_stat_short"}, stat_short_pkts, exp_short);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    always @(posedge aclk) begin
        #1;
        axis_out_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: pops and compares every transferred beat, checks hold during stalls
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    always @(negedge aclk) begin
        beat_t cur;
        beat_t e;
        cur = {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tid};
        if (prev_stall) check("stall_hold", {axis_out_tvalid, cur}, {1'b1, prev_beat});
        if (axis_out_tvalid && axis_out_tready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: actual=%0h required=none", cur);
            end else begin
                e = sb_q.pop_front();
                check("out_beat", cur, e);
            end
        end
        prev_stall = axis_out_tvalid && !axis_out_tready && !areset;
        prev_beat  = cur;
    end

    initial begin
        bytes_t b;
        int     len;
        logic [3:0] tid;
        logic   vx;

        areset           = 1'b1;
        axis_in_tdata    = '0;
        axis_in_tid      = '0;
        axis_in_tkeep    = '0;
        axis_in_tlast    = 1'b0;
        axis_in_tvalid   = 1'b0;
        vsid_config_regs = 1'b0;
        vsid_cam_values  = '0;
        for (int j = 0; j < NID; j++) sl[j] = '0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_in_tready", axis_in_tready, 0);
        check("rst_out_tvalid", axis_out_tvalid, 0);
        check("rst_out_tdata", axis_out_tdata, 0);
        check("rst_out_tkeep", axis_out_tkeep, 0);
        check("rst_out_tlast", axis_out_tlast, 0);
        check("rst_out_tid", axis_out_tid, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // VXLAN vsid only, 80 zero bytes
        set_slice(3, mk_slice(1'b0, 48'h0, 1'b1, 32'h00AB_CDEF));
        in_q  = pack(zeros(80), 4'd3);
        exp_q = in_q;
        exp_q[5].data = 64'hCDAB_0000_0000_0000;
        exp_q[6].data = 64'h0000_0000_0000_00EF;
        drive_pkt(in_q.size(), 99, 1'b1);
        exp_tag++;

        // NVGRE with MAC insertion
        set_slice(3, mk_slice(1'b1, 48'h0A0B_0C0D_0E0F, 1'b1, 32'h00AB_CDEF));
        in_q  = pack(zeros(80), 4'd3);
        exp_q = in_q;
        exp_q[0].data = 64'h0000_0F0E_0D0C_0B0A;
        exp_q[4].data = 64'hCDAB_0000_0000_0000;
        exp_q[5].data = 64'h0000_0000_0000_00EF;
        drive_pkt(in_q.size(), 99, 1'b0);
        exp_tag++;

        // 47-byte VXLAN packet; dead lane 7 of last beat must be untouched
        set_slice(3, mk_slice(1'b0, 48'h0, 1'b1, 32'h00AB_CDEF));
        in_q  = pack(zeros(47), 4'd3);
        in_q[5].data[63:56] = 8'h55;
        exp_q = in_q;
        exp_q[5].data = 64'h55AB_0000_0000_0000;
        check("short_last_keep", in_q[5].keep, 8'h7F);
        drive_pkt(in_q.size(), 99, 1'b1);
        exp_tag++;
        exp_short++;
        wait_drain();
        check_stats("directed");

        // tid and config toggled at beat 3; tagging must follow first-beat values
        set_slice(5, mk_slice(1'b1, 48'h1111_1111_1111, 1'b1, 32'h0012_3456));
        in_q = pack(zeros(80), 4'd3);
        for (int i = 3; i < 10; i++) in_q[i].tid = 4'd5;
        exp_q = in_q;
        exp_q[5].data = 64'hCDAB_0000_0000_0000;
        exp_q[6].data = 64'h0000_0000_0000_00EF;
        drive_pkt(10, 3, 1'b1);
        exp_tag++;
        wait_drain();

        // Reset while beat 4 is offered
        set_slice(3, mk_slice(1'b1, 48'h0A0B_0C0D_0E0F, 1'b1, 32'h00AB_CDEF));
        in_q  = pack(zeros(80), 4'd3);
        exp_q = in_q;
        exp_q[0].data = 64'h0000_0F0E_0D0C_0B0A;
        drive_pkt(4, 99, 1'b1);
        areset         = 1'b1;
        axis_in_tdata  = in_q[4].data;
        axis_in_tkeep  = in_q[4].keep;
        axis_in_tlast  = in_q[4].last;
        axis_in_tvalid = 1'b1;
        @(negedge aclk);
        check("reset_in_tready", axis_in_tready, 0);
        @(posedge aclk);
        #1;
        check("reset_out_tvalid", axis_out_tvalid, 0);
        areset         = 1'b0;
        axis_in_tvalid = 1'b0;
        exp_tag        = 0;
        exp_short      = 0;
        in_q  = pack(zeros(80), 4'd3);
        exp_q = in_q;
        exp_q[0].data = 64'h0000_0F0E_0D0C_0B0A;
        exp_q[4].data = 64'hCDAB_0000_0000_0000;
        exp_q[5].data = 64'h0000_0000_0000_00EF;
        drive_pkt(in_q.size(), 99, 1'b0);
        exp_tag++;
        wait_drain();
        check_stats("after_reset");

        // Random backpressure over 100 packets against the byte-space model
        rand_rdy = 1'b1;
        for (int j = 0; j < NID; j++) begin
            set_slice(j, mk_slice(1'($urandom), {16'($urandom), $urandom}, 1'($urandom), $urandom));
        end
        for (int p = 0; p < 100; p++) begin
            b.delete();
            len = $urandom_range(1, 90);
            tid = 4'($urandom_range(0, NID - 1));
            vx  = 1'($urandom);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            in_q  = pack(b, tid);
            exp_q = pack(edit(b, vx, sl[tid]), tid);
            drive_pkt(in_q.size(), 99, vx);
            if (sl[tid][81] || sl[tid][32]) begin
                exp_tag++;
                if (is_short(len, vx, sl[tid])) exp_short++;
            end
        end
        wait_drain();
        rand_rdy = 1'b0;
        check_stats("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
